// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
//   state_e       : drain-engine state (idle, running, finishing a burst)
//   BURST_COUNT_W : width of the completed-burst counter
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    localparam int unsigned BURST_COUNT_W = 16;

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry first-in/first-out output buffer for the FIFO burst reader.
// Entry 0 is always the head, so the head word never moves while it is not popped.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write push_data_i at the end of this cycle
//   push_data_i  : word to write
//   pop_i        : drop the head at the end of this cycle
//   occ_o        : number of stored words, 0..2
//   head_data_o  : oldest stored word
module fifo_reader_buf #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]            occ_q, occ_d;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        occ_d    = occ_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) entry0_d = push_data_i;
                else               entry1_d = push_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                occ_d    = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word goes behind whatever survives the pop.
                if (occ_q == 2'd2) begin
                    entry0_d = entry1_q;
                    entry1_d = push_data_i;
                end else begin
                    entry0_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry0_q <= '0;
            entry1_q <= '0;
            occ_q    <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            occ_q    <= occ_d;
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = entry0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side drain engine for fifo_sync: pops words, hides the one-cycle read latency and
// presents them as a valid/ready stream grouped into BURST_LEN-word bursts. Stopping is
// burst-atomic: a burst that has started being read is always read to its end.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   enable_i              : run request (level)
//   fifo_empty_i          : FIFO empty flag
//   fifo_data_i           : FIFO data_out, valid the cycle after an accepted read
//   fifo_cs_o, fifo_rd_en_o : FIFO chip select / read strobe (identical)
//   m_valid_o, m_ready_i, m_data_o, m_last_o : output stream
//   busy_o                : engine active, words buffered or a read in flight
//   burst_count_o         : completed bursts on the stream, wrapping
module fifo_burst_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]    fifo_data_i,
    output logic                     fifo_cs_o,
    output logic                     fifo_rd_en_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [DATA_WIDTH-1:0]    m_data_o,
    output logic                     m_last_o,
    output logic                     busy_o,
    output logic [BURST_COUNT_W-1:0] burst_count_o
);

    localparam int unsigned IdxW = $clog2(BURST_LEN + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BURST_LEN - 1);

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          rd_idx_q, rd_idx_d;
    logic [IdxW-1:0]          out_idx_q, out_idx_d;
    logic [BURST_COUNT_W-1:0] burst_count_q, burst_count_d;
    logic                     inflight_q;

    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic [2:0]            pending;
    logic                  active, pop, rd_en, rd_last, out_last;

    assign active   = (state_q != StIdle);
    assign m_valid_o = (occ != 2'd0);
    assign pop      = m_valid_o & m_ready_i;
    // Words already committed to the buffer (stored plus in flight) must leave room,
    // counting a slot freed by this cycle's pop.
    assign pending  = {1'b0, occ} + {2'b00, inflight_q};
    assign rd_en    = ~rst_i & active & ~fifo_empty_i & (pending < (3'd2 + {2'b00, pop}));
    assign rd_last  = (rd_idx_q == LastIdx);
    assign out_last = (out_idx_q == LastIdx);

    always_comb begin
        rd_idx_d      = rd_idx_q;
        out_idx_d     = out_idx_q;
        burst_count_d = burst_count_q;
        if (rd_en) rd_idx_d = rd_last ? '0 : rd_idx_q + 1'b1;
        if (pop) begin
            out_idx_d = out_last ? '0 : out_idx_q + 1'b1;
            if (out_last) burst_count_d = burst_count_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enable_i) state_d = StRun;
            // Judge "mid-burst" after this cycle's read so a read issued now is never orphaned.
            StRun:    if (!enable_i) state_d = (rd_idx_d != '0) ? StFinish : StIdle;
            StFinish: if (rd_en && rd_last) state_d = enable_i ? StRun : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            rd_idx_q      <= '0;
            out_idx_q     <= '0;
            burst_count_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_idx_q      <= rd_idx_d;
            out_idx_q     <= out_idx_d;
            burst_count_q <= burst_count_d;
            inflight_q    <= rd_en;
        end
    end

    fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_i),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_data_o (head_data)
    );

    assign fifo_rd_en_o  = rd_en;
    assign fifo_cs_o     = rd_en;
    assign m_data_o      = head_data;
    assign m_last_o      = m_valid_o & out_last;
    assign busy_o        = active | (occ != 2'd0) | inflight_q;
    assign burst_count_o = burst_count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int BL = 4;

    logic       clk;
    logic       rst, enable, fifo_empty, m_ready;
    logic [7:0] fifo_data;
    logic       fifo_cs, fifo_rd_en, m_valid, m_last, busy;
    logic [7:0] m_data;
    logic [15:0] burst_count;

    // Second instance with single-word bursts for the counter wrap.
    logic       rst2, en2, empty2;
    logic [7:0] data2;
    logic       cs2, rd2, valid2, last2, busy2;
    logic [7:0] mdata2;
    logic [15:0] bc2;

    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(BL)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_cs_o(fifo_cs), .fifo_rd_en_o(fifo_rd_en),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .busy_o(busy), .burst_count_o(burst_count)
    );

    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(1)) dut2 (
        .clk_i(clk), .rst_i(rst2), .enable_i(en2), .fifo_empty_i(empty2),
        .fifo_data_i(data2), .fifo_cs_o(cs2), .fifo_rd_en_o(rd2),
        .m_valid_o(valid2), .m_ready_i(1'b1), .m_data_o(mdata2), .m_last_o(last2),
        .busy_o(busy2), .burst_count_o(bc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests, n_fail;

    // FIFO contents, words read but not yet streamed, and stream record.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_data[$];
    bit         got_last[$];
    int         got_cyc[$];

    int ready_words, r1, outstanding, words_out, burst_exp, reads_sr, cyc, first_rd_cyc;
    bit stalled_prev, prev_en;
    logic [7:0] data_prev;
    logic s_rd, s_cs, s_valid, s_last, s_busy;
    logic [7:0] s_data;
    logic [15:0] s_bc;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // One clock cycle: starts at posedge+1 with inputs driven, samples at posedge+4,
    // checks against the model, advances the model and the FIFO, returns at posedge+1.
    task automatic step();
        bit pop, rst_s, exp_last;
        fifo_empty = (fifo_q.size() == 0);
        #3;
        s_rd = fifo_rd_en; s_cs = fifo_cs; s_valid = m_valid; s_last = m_last;
        s_data = m_data; s_busy = busy; s_bc = burst_count;
        rst_s = rst;
        cyc++;
        if (rst_s) begin
            check("rd_en_in_reset", s_rd, 0);
        end else begin
            pop = s_valid & m_ready;
            check("cs_eq_rd_en", s_cs, s_rd);
            if (s_rd) check("rd_while_empty", fifo_empty, 0);
            if (s_rd) check("rd_overrun", (outstanding - int'(pop)) < 2, 1);
            if (prev_en && !fifo_empty && (outstanding - int'(pop)) < 2)
                check("rd_issue", s_rd, 1);
            check("m_valid", s_valid, ready_words > 0);
            if (stalled_prev) check("stall_hold", s_data, data_prev);
            check("burst_count", s_bc, burst_exp);
            if (s_valid && exp_q.size() != 0) begin
                exp_last = (words_out % BL) == BL - 1;
                check("m_data", s_data, exp_q[0]);
                check("m_last", s_last, exp_last);
            end else begin
                check("m_last_idle", s_last, 0);
            end
            if (pop && exp_q.size() != 0) begin
                got_data.push_back(s_data);
                got_last.push_back(s_last);
                got_cyc.push_back(cyc);
                void'(exp_q.pop_front());
                words_out++;
                if (words_out % BL == 0) burst_exp = (burst_exp + 1) % 65536;
            end
            ready_words = ready_words - int'(pop) + r1;
            r1 = s_rd;
            outstanding = outstanding + int'(s_rd) - int'(pop);
            if (s_rd) begin
                reads_sr++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            stalled_prev = s_valid & ~m_ready;
            data_prev = s_data;
        end
        prev_en = enable & ~rst_s;
        @(posedge clk);
        #1;
        if (rst_s) begin
            exp_q.delete();
            ready_words = 0; r1 = 0; outstanding = 0; words_out = 0; burst_exp = 0;
            reads_sr = 0; stalled_prev = 0;
        end
        if (s_rd && fifo_q.size() != 0) begin
            fifo_data = fifo_q.pop_front();
            if (!rst_s) exp_q.push_back(fifo_data);
        end
    endtask

    task automatic clear_got();
        got_data.delete(); got_last.delete(); got_cyc.delete(); first_rd_cyc = -1;
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + 8'(i)));
    endtask

    initial begin
        int base, remaining, pops2, bad;
        n_tests = 0; n_fail = 0; cyc = 0;
        ready_words = 0; r1 = 0; outstanding = 0; words_out = 0; burst_exp = 0;
        reads_sr = 0; stalled_prev = 0; prev_en = 0; data_prev = '0; first_rd_cyc = -1;
        rst = 1; enable = 0; m_ready = 0; fifo_data = '0; fifo_empty = 1;
        rst2 = 1; en2 = 0; empty2 = 1; data2 = '0;

        // Reset state
        repeat (3) step();
        rst = 0;
        step();
        check("rst_rd_en", s_rd, 0);
        check("rst_cs", s_cs, 0);
        check("rst_m_valid", s_valid, 0);
        check("rst_m_data", s_data, 0);
        check("rst_m_last", s_last, 0);
        check("rst_busy", s_busy, 0);
        check("rst_burst_count", s_bc, 0);

        // Basic burst
        preload(8'h11, 8); clear_got();
        enable = 1; m_ready = 1;
        for (int k = 0; k < 40 && got_data.size() < 8; k++) step();
        check("basic_count", got_data.size(), 8);
        if (got_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("basic_data", got_data[i], 8'(8'h11 + 8'(i)));
                check("basic_last", got_last[i], (i % 4) == 3);
                check("basic_rate", got_cyc[i], got_cyc[0] + i);
            end
            check("basic_latency", got_cyc[0] - first_rd_cyc, 2);
        end
        step();
        check("basic_bursts", s_bc, 2);
        enable = 0;
        repeat (3) step();
        check("basic_idle_busy", s_busy, 0);

        // Backpressure with ready pattern 1,0,0,1
        preload(8'h11, 8); clear_got();
        enable = 1;
        for (int k = 0; k < 80 && got_data.size() < 8; k++) begin
            m_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        check("bp_count", got_data.size(), 8);
        for (int i = 0; i < got_data.size(); i++)
            check("bp_data", got_data[i], 8'(8'h11 + 8'(i)));
        m_ready = 1; enable = 0;
        repeat (2) step();
        check("bp_bursts", s_bc, 4);

        // Burst-atomic stop after two reads
        preload(8'h31, 8); clear_got();
        base = reads_sr;
        enable = 1;
        for (int k = 0; k < 20 && reads_sr - base < 2; k++) step();
        enable = 0;
        repeat (10) step();
        check("stop_reads", reads_sr - base, 4);
        check("stop_words", got_data.size(), 4);
        if (got_data.size() == 4) begin
            check("stop_last_data", got_data[3], 8'h34);
            check("stop_last_flag", got_last[3], 1);
        end
        check("stop_busy", s_busy, 0);
        check("stop_idle_rd", s_rd, 0);
        check("stop_fifo_left", fifo_q.size(), 4);
        fifo_q.delete();

        // FIFO runs empty mid-burst
        preload(8'h41, 3); clear_got();
        enable = 1;
        repeat (10) step();
        check("empty_words", got_data.size(), 3);
        for (int i = 0; i < got_data.size(); i++) check("empty_no_last", got_last[i], 0);
        fifo_q.push_back(8'h44);
        repeat (6) step();
        check("resume_words", got_data.size(), 4);
        if (got_data.size() == 4) begin
            check("resume_data", got_data[3], 8'h44);
            check("resume_last", got_last[3], 1);
        end
        enable = 0;
        repeat (3) step();

        // Reset with a full output buffer
        preload(8'h51, 4);
        enable = 1; m_ready = 0;
        repeat (6) step();
        check("pre_rst_valid", s_valid, 1);
        check("pre_rst_full", outstanding, 2);
        rst = 1;
        step();
        rst = 0;
        step();
        check("post_rst_valid", s_valid, 0);
        check("post_rst_bursts", s_bc, 0);
        check("post_rst_rd", s_rd, 0);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            enable = $urandom_range(0, 9) < 7;
            m_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
            step();
        end
        preload(8'h80, 8);
        enable = 0; m_ready = 1;
        repeat (30) step();
        check("drain_busy", s_busy, 0);
        check("drain_whole_bursts", reads_sr % BL, 0);
        check("drain_outstanding", outstanding, 0);

        // Counter wrap with single-word bursts
        rst2 = 0; en2 = 1; remaining = 65537; pops2 = 0; bad = 0;
        for (int c = 0; c < 65600; c++) begin
            empty2 = (remaining == 0);
            #3;
            if (rd2) begin
                if (remaining == 0) bad++;
                else remaining--;
            end
            if (valid2 !== last2) bad++;
            if (bc2 !== 16'(pops2)) bad++;
            if (valid2) pops2++;
            @(posedge clk);
            #1;
        end
        #3;
        check("wrap_words", pops2, 65537);
        check("wrap_burst_count", bc2, 1);
        check("wrap_fifo_drained", remaining, 0);
        check("wrap_per_cycle", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
